// File: rtl/iiitb_sqg_1010.sv
// iiitb_sqg_1010: framed serial pattern transmitter.
// Sends sync word 1010 then the payload MSB-first; line idles low between frames.
module iiitb_sqg_1010 #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              dout,
    output logic              busy,
    output logic              frame_done
);

    localparam int MAXD = (DATA_W > 4) ? DATA_W : 4;
    localparam int MAXL = (GAP_CYCLES > MAXD) ? GAP_CYCLES : MAXD;
    localparam int CW   = $clog2(MAXL) + 1;

    localparam logic [3:0]    SYNC_WORD = 4'b1010;
    localparam logic [CW-1:0] SYNC_LAST = CW'(3);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] GAP_LAST  =
        (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA,
        GAP
    } state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [DATA_W-1:0] sreg, sreg_d;
    logic              dout_d;
    logic              frame_done_d;

    // Outputs are registered from the next-state view so the bit for a
    // state appears in the same cycle that state is current.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sreg       <= '0;
            dout       <= 1'b0;
            din_ready  <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            sreg       <= sreg_d;
            dout       <= dout_d;
            din_ready  <= (state_d == IDLE);
            busy       <= (state_d != IDLE);
            frame_done <= frame_done_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        sreg_d  = sreg;
        unique case (state)
            IDLE: begin
                if (din_valid) begin
                    state_d = SYNC;
                    cnt_d   = SYNC_LAST;
                    sreg_d  = din;
                end
            end
            SYNC: begin
                if (cnt == '0) begin
                    state_d = DATA;
                    cnt_d   = DATA_LAST;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LAST;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d  = cnt - CW'(1);
                    sreg_d = sreg << 1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        dout_d       = 1'b0;
        frame_done_d = 1'b0;
        unique case (state_d)
            SYNC: dout_d = SYNC_WORD[cnt_d[1:0]];
            DATA: begin
                dout_d       = sreg_d[DATA_W-1];
                frame_done_d = (cnt_d == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: doc/iiitb_sqg_1010.md
# iiitb_sqg_1010

Framed serial pattern transmitter and the transmit-side counterpart of the 1010 sequence detector. It accepts a parallel payload word over a valid/ready handshake. It then serializes a frame of the 4-bit sync word 1010 followed by the payload MSB-first on a single registered bit line, so a detector on the far end can lock on the sync word. Between frames the line idles at 0, which holds a downstream detector in its reset state.

## Interface
- DATA_W, 8: payload width in bits; legal range is at least 1.
- GAP_CYCLES, 1: extra forced-0 cycles after each frame, before the block re-enters IDLE; legal range is at least 0.
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  DATA_W  payload word, sampled only on an accepted handshake.
- din_valid  input  1  upstream has a word on din.
- din_ready  output  1  block can accept a word; high only in IDLE.
- dout  output  1  registered serial bit stream.
- busy  output  1  high while a frame or gap is in progress (any state other than IDLE).
- frame_done  output  1  one-cycle pulse coincident with the last payload bit on dout.

## Operation
- The sync word is the constant 4'b1010, sent MSB-first as 1, 0, 1, 0.
- States:
  - IDLE: dout=0, din_ready=1, busy=0. If din_valid=1, capture din into the shift register and go to SYNC. Otherwise stay in IDLE.
  - SYNC: drive the 4 sync bits over 4 cycles, then go to DATA.
  - DATA: drive DATA_W payload bits MSB-first over DATA_W cycles. frame_done=1 on the last one. Then go to GAP if GAP_CYCLES>0, else go to IDLE.
  - GAP: dout=0 for GAP_CYCLES cycles, then go to IDLE.
- One down-counter is reused for the sync, payload and gap lengths. It is sized to ceil(log2(max(4, DATA_W, GAP_CYCLES)))+1 bits and reloaded on every state entry. It never wraps.
- The payload is captured at acceptance, so upstream may change din or drop din_valid on the next cycle.
- din_valid while din_ready=0 is ignored; no word is consumed. The upstream holds din_valid until it sees din_ready.
- Reset values:
  - dout=0, din_ready=1, busy=0, frame_done=0.
  - state is IDLE, and the counter and shift register are 0.
- Reset mid-frame, in any state: on the next edge the block returns to the reset values and the partial frame is abandoned. No frame_done is produced for it.
- Reset has priority over a simultaneous handshake; the word is not accepted.

## Timing
- Let edge k be the rising edge at which din_valid=1 and din_ready=1.
- Cycles k+1 to k+4: dout = 1, 0, 1, 0.
- Cycles k+5 to k+4+DATA_W: dout = din[DATA_W-1] down to din[0].
- frame_done=1 only in cycle k+4+DATA_W.
- busy=1 and din_ready=0 from cycle k+1 through the last GAP cycle.
- The next IDLE cycle has dout=0 and din_ready=1. The earliest next acceptance is the edge ending that cycle.
- The minimum zero-gap between frames is therefore GAP_CYCLES+1 bits.
- Frame period with a continuously valid upstream is 4 + DATA_W + GAP_CYCLES + 1 cycles: 14 cycles at the defaults.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset, then din=8'hA5 with din_valid held high:
  - Accept on the first edge after reset is released.
  - dout = 1,0,1,0,1,0,1,0,0,1,0,1,0, then 0.
  - frame_done is high only on the 12th bit.
  - din_ready returns high 14 cycles after the accept.
- din_valid held high with words 8'h3C then 8'hC3:
  - Two back-to-back frames, 14 cycles apart.
  - Between them, exactly 2 zero bits (GAP plus IDLE).
  - Each payload appears MSB-first.
- din_valid pulsed with din=8'hFF while busy=1:
  - No word is accepted and the current frame is unchanged.
  - A later pulse in IDLE is accepted normally.
- Reset asserted during the 3rd payload bit:
  - Next cycle dout=0, busy=0, din_ready=1, frame_done=0.
  - A new word sent afterwards produces a clean full frame.
- GAP_CYCLES=0, DATA_W=4, din=4'h9:
  - dout = 1,0,1,0,1,0,0,1, then 0.
  - din_ready is high exactly one cycle later.
- Loopback into the 1010 detector (shared clk and reset):
  - Payloads 8'h00 and 8'hF0 each give exactly one y pulse.
  - The pulse falls in cycle k+4, the last sync bit.
